// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: fetches one 4-word I-cache line on a miss, then commits tag and valid
module icache_refill_ctrl #(
  parameter int INDEX_BITS     = 7,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_BITS       = 32 - INDEX_BITS - 4,
  parameter int THREAD_BITS    = 2
) (
  input  logic                          clk_i,
  input  logic                          nReset_i,
  input  logic                          Miss_i,
  input  logic [31:0]                   MissAddr_i,
  input  logic [THREAD_BITS-1:0]        MissThread_i,
  output logic                          Busy_o,
  output logic                          MemReq_o,
  output logic [31:0]                   MemAddr_o,
  input  logic                          MemAck_i,
  input  logic                          MemRValid_i,
  input  logic [31:0]                   MemRData_i,
  output logic                          DataWrite_o,
  output logic [$clog2(WORDS_PER_LINE)-1:0] DataWordSel_o,
  output logic [31:0]                   DataWord_o,
  output logic                          TagWrite_o,
  output logic [TAG_BITS-1:0]           TagOut_o,
  output logic                          WriteValid_o,
  output logic [INDEX_BITS-1:0]         CacheIndexWrite_o,
  output logic                          RefillDone_o,
  output logic [THREAD_BITS-1:0]        DoneThread_o
);
  localparam int CW = $clog2(WORDS_PER_LINE);
  typedef enum logic [1:0] {IDLE, REQ, FILL, COMMIT} state_t;
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [INDEX_BITS-1:0]  idx_q;
  logic [TAG_BITS-1:0]    tag_q;
  logic [THREAD_BITS-1:0] thr_q;
  logic                   busy_q, mem_req_q, data_write_q, tag_write_q, write_valid_q, done_q;
  logic [31:0]            mem_addr_q, data_word_q;
  logic [CW-1:0]          word_sel_q;
  logic [TAG_BITS-1:0]    tag_out_q;
  logic [INDEX_BITS-1:0]  cidx_q;
  logic [THREAD_BITS-1:0] done_thr_q;
  // Refill FSM: COMMIT spans two cycles, pulsing the commit strobes first and releasing Busy second
  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      tag_q         <= '0;
      thr_q         <= '0;
      busy_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      data_write_q  <= 1'b0;
      word_sel_q    <= '0;
      data_word_q   <= '0;
      tag_write_q   <= 1'b0;
      tag_out_q     <= '0;
      write_valid_q <= 1'b0;
      cidx_q        <= '0;
      done_q        <= 1'b0;
      done_thr_q    <= '0;
    end else begin
      data_write_q  <= 1'b0;
      tag_write_q   <= 1'b0;
      write_valid_q <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        IDLE: if (Miss_i) begin
          state_q    <= REQ;
          busy_q     <= 1'b1;
          mem_req_q  <= 1'b1;
          mem_addr_q <= MissAddr_i & 32'hFFFF_FFF0;
          idx_q      <= MissAddr_i[INDEX_BITS+3:4];
          tag_q      <= MissAddr_i[31:INDEX_BITS+4];
          thr_q      <= MissThread_i;
        end
        REQ: if (MemAck_i) begin
          mem_req_q <= 1'b0;
          state_q   <= FILL;
        end
        FILL: if (MemRValid_i) begin
          data_write_q <= 1'b1;
          word_sel_q   <= cnt_q;
          data_word_q  <= MemRData_i;
          cidx_q       <= idx_q;
          cnt_q        <= cnt_q + 1'b1;
          if (cnt_q == CW'(WORDS_PER_LINE - 1)) state_q <= COMMIT;
        end
        COMMIT: if (!write_valid_q) begin
          write_valid_q <= 1'b1;
          tag_write_q   <= 1'b1;
          tag_out_q     <= tag_q;
          cidx_q        <= idx_q;
          done_q        <= 1'b1;
          done_thr_q    <= thr_q;
        end else begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign Busy_o            = busy_q;
  assign MemReq_o          = mem_req_q;
  assign MemAddr_o         = mem_addr_q;
  assign DataWrite_o       = data_write_q;
  assign DataWordSel_o     = word_sel_q;
  assign DataWord_o        = data_word_q;
  assign TagWrite_o        = tag_write_q;
  assign TagOut_o          = tag_out_q;
  assign WriteValid_o      = write_valid_q;
  assign CacheIndexWrite_o = cidx_q;
  assign RefillDone_o      = done_q;
  assign DoneThread_o      = done_thr_q;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: randomized refill stimulus with a queue-based scoreboard
module tb_icache_refill_ctrl;
  logic        clk = 1'b0, nReset = 1'b0;
  logic        Miss = 1'b0, MemAck = 1'b0, MemRValid = 1'b0;
  logic [31:0] MissAddr = '0, MemRData = '0;
  logic [1:0]  MissThread = '0;
  logic        Busy_o, MemReq_o, DataWrite_o, TagWrite_o, WriteValid_o, RefillDone_o;
  logic [31:0] MemAddr_o, DataWord_o;
  logic [1:0]  DataWordSel_o, DoneThread_o;
  logic [20:0] TagOut_o;
  logic [6:0]  CacheIndexWrite_o;
  int checks = 0, failures = 0, cyc = 0;
  int gaps[4];
  typedef struct { int c; logic [6:0] idx; logic [1:0] w; logic [31:0] d; } dw_t;
  typedef struct { int c; logic [20:0] tag; logic [6:0] idx; logic [1:0] th; } cm_t;
  dw_t dq[$];
  cm_t cq[$];

  icache_refill_ctrl dut (
    .clk_i(clk), .nReset_i(nReset), .Miss_i(Miss), .MissAddr_i(MissAddr), .MissThread_i(MissThread),
    .Busy_o(Busy_o), .MemReq_o(MemReq_o), .MemAddr_o(MemAddr_o), .MemAck_i(MemAck),
    .MemRValid_i(MemRValid), .MemRData_i(MemRData), .DataWrite_o(DataWrite_o),
    .DataWordSel_o(DataWordSel_o), .DataWord_o(DataWord_o), .TagWrite_o(TagWrite_o),
    .TagOut_o(TagOut_o), .WriteValid_o(WriteValid_o), .CacheIndexWrite_o(CacheIndexWrite_o),
    .RefillDone_o(RefillDone_o), .DoneThread_o(DoneThread_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // Monitor: every data write and every commit must match the next expected entry, at its expected cycle
  always @(negedge clk) begin
    dw_t e;
    cm_t m;
    if (nReset) begin
      if (DataWrite_o) begin
        if (dq.size() == 0) chk("dw_unexpected", DataWrite_o, 0);
        else begin
          e = dq.pop_front();
          chk("dw_cycle", cyc, e.c);
          chk("dw_idx", CacheIndexWrite_o, e.idx);
          chk("dw_word", DataWordSel_o, e.w);
          chk("dw_data", DataWord_o, e.d);
        end
      end
      if (WriteValid_o || TagWrite_o || RefillDone_o) begin
        if (cq.size() == 0) chk("commit_unexpected", {WriteValid_o, TagWrite_o, RefillDone_o}, 0);
        else begin
          m = cq.pop_front();
          chk("cm_cycle", cyc, m.c);
          chk("cm_strobes", {WriteValid_o, TagWrite_o, RefillDone_o, Busy_o, DataWrite_o}, 5'b11110);
          chk("cm_tag", TagOut_o, m.tag);
          chk("cm_idx", CacheIndexWrite_o, m.idx);
          chk("cm_thread", DoneThread_o, m.th);
        end
      end
    end
  end

  task automatic refill(input logic [31:0] a, input logic [1:0] th, input int ack, input bit started,
                        input bit poke, input bit chain, input logic [31:0] ca, input logic [1:0] ct);
    int g;
    logic [31:0] d;
    if (!started) begin
      Miss = 1'b1; MissAddr = a; MissThread = th;
      @(posedge clk); #1;
      Miss = 1'b0; MissAddr = $urandom;
    end
    chk("req_memreq", MemReq_o, 1);
    chk("req_busy", Busy_o, 1);
    chk("req_addr", MemAddr_o, a & 32'hFFFF_FFF0);
    for (int i = 0; i < ack; i++) begin
      MemRValid = 1'($urandom_range(0, 1)); MemRData = $urandom;
      @(posedge clk); #1;
      chk("req_hold", MemReq_o, 1);
    end
    MemAck = 1'b1; MemRValid = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    MemAck = 1'b0; MemRValid = 1'b0;
    chk("req_drop", MemReq_o, 0);
    if (poke) begin Miss = 1'b1; MissAddr = a ^ 32'h0F0F_0FF0; MissThread = ~th; end
    for (int b = 0; b < 4; b++) begin
      g = gaps[b] < 0 ? int'($urandom_range(0, 2)) : gaps[b];
      repeat (g) begin @(posedge clk); #1; end
      d = $urandom;
      MemRValid = 1'b1; MemRData = d;
      dq.push_back('{cyc + 1, a[10:4], b[1:0], d});
      if (b == 3) cq.push_back('{cyc + 2, a[31:11], a[10:4], th});
      @(posedge clk); #1;
      MemRValid = 1'b0;
    end
    Miss = 1'b0;
    MemRValid = 1'b1; MemRData = $urandom;
    @(posedge clk); #1;
    MemRValid = 1'b0;
    if (chain) begin Miss = 1'b1; MissAddr = ca; MissThread = ct; end
    @(posedge clk); #1;
    chk("post_busy", Busy_o, 0);
    chk("post_memreq", MemReq_o, 0);
    chk("post_wv", WriteValid_o, 0);
    if (chain) begin @(posedge clk); #1; Miss = 1'b0; end
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      MemAck = 1'($urandom_range(0, 1)); MemRValid = 1'($urandom_range(0, 1)); MemRData = $urandom;
      @(posedge clk); #1;
      chk(tag, {MemReq_o, Busy_o, WriteValid_o, DataWrite_o, RefillDone_o}, 0);
    end
    MemAck = 1'b0; MemRValid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {Busy_o, MemReq_o, DataWrite_o, TagWrite_o, WriteValid_o, RefillDone_o}, 0);
    chk("rst_data", {MemAddr_o, DataWord_o, TagOut_o, CacheIndexWrite_o, DoneThread_o, DataWordSel_o}, 0);
    nReset = 1'b1;
    idle_check(10, "idle_after_reset");
    gaps = '{0, 0, 0, 0};
    refill(32'h0000_1234, 2'd2, 2, 0, 0, 0, 0, 0);
    gaps = '{0, 2, 0, 4};
    refill(32'h0000_4560, 2'd1, 1, 0, 0, 0, 0, 0);
    gaps = '{0, 0, 0, 0};
    refill(32'hFFFF_FFF0, 2'd3, 0, 0, 0, 0, 0, 0);
    refill(32'h0000_1234, 2'd0, 1, 0, 0, 0, 0, 0);
    Miss = 1'b1; MissAddr = 32'h0000_5670; MissThread = 2'd1;
    @(posedge clk); #1;
    Miss = 1'b0;
    MemAck = 1'b1;
    @(posedge clk); #1;
    MemAck = 1'b0;
    for (int w = 0; w < 2; w++) begin
      d = $urandom;
      MemRValid = 1'b1; MemRData = d;
      dq.push_back('{cyc + 1, 7'h67, w[1:0], d});
      @(posedge clk); #1;
      MemRValid = 1'b0;
    end
    @(posedge clk); #1;
    nReset = 1'b0;
    #1;
    chk("midrst_strobes", {Busy_o, MemReq_o, DataWrite_o, TagWrite_o, WriteValid_o, RefillDone_o}, 0);
    repeat (2) @(posedge clk);
    #1;
    nReset = 1'b1;
    idle_check(10, "late_beats_ignored");
    gaps = '{-1, -1, -1, -1};
    refill(32'h0000_5670, 2'd1, 1, 0, 0, 0, 0, 0);
    refill(32'h0000_2000, 2'd0, 1, 0, 1, 1, 32'h0ABC_DEF4, 2'd3);
    refill(32'h0ABC_DEF4, 2'd3, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      refill($urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3), 0, k[0], 0, 0, 0);
    idle_check(3, "final_idle");
    chk("dw_drained", dq.size(), 0);
    chk("cm_drained", cq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Instruction-cache miss/refill controller for the multithreaded RISC-V fetch path. It accepts a line miss from fetch and fetches one 4-word line from instruction memory over a request/ack + beat-valid interface. It writes data words into the line array, then writes tag and valid. It drives the write side of the instruction valid memory (WriteValid, CacheIndexWrite) and reports refill completion per thread.

Parameters:
INDEX_BITS, 7, cache index width (128 lines)
WORDS_PER_LINE, 4, 32-bit words per line (offset = 4 byte-address bits)
TAG_BITS, 21, 32 - INDEX_BITS - 4
THREAD_BITS, 2, thread id width

Ports:
clk  in  1  clock, rising edge
nReset  in  1  asynchronous active-low reset
Miss  in  1  fetch miss request, level; sampled only in IDLE
MissAddr  in  32  byte address of missing fetch
MissThread  in  THREAD_BITS  thread owning the miss
Busy  out  1  refill in progress; fetch must hold Miss stable while high
MemReq  out  1  line read request to instruction memory
MemAddr  out  32  line-aligned address (bits 3:0 = 0)
MemAck  in  1  memory accepted MemReq
MemRValid  in  1  one read beat valid
MemRData  in  32  read beat data
DataWrite  out  1  line-array word write strobe
DataWordSel  out  2  word within line
DataWord  out  32  word to write
TagWrite  out  1  tag-array write strobe
TagOut  out  TAG_BITS  tag to write
WriteValid  out  1  valid-memory set strobe
CacheIndexWrite  out  INDEX_BITS  line index for data/tag/valid writes
RefillDone  out  1  one-cycle completion pulse
DoneThread  out  THREAD_BITS  thread for RefillDone

Behaviour:
- Reset (async, nReset=0): state IDLE, beat counter 0. All strobes low: Busy, MemReq, DataWrite, TagWrite, WriteValid, RefillDone. All data/address outputs 0. Reset mid-refill abandons the line with no valid write. Beats arriving after reset are ignored.
- All outputs are registered.
- States: IDLE, REQ, FILL, COMMIT.
- IDLE:
  - Miss=1 at edge -> capture line address (MissAddr[31:4]), index (MissAddr[10:4]), tag (MissAddr[31:11]) and MissThread.
  - Next cycle: state REQ, Busy=1, MemReq=1, MemAddr={MissAddr[31:4],4'b0}.
  - MemRValid and MemAck are ignored in IDLE.
- REQ:
  - MemReq held high until MemAck sampled high. MemReq is low from the following cycle; state becomes FILL.
  - MemRValid is ignored in REQ; the first beat is no earlier than the cycle after MemAck.
- FILL:
  - Each MemRValid beat at cycle t produces, in cycle t+1: DataWrite=1, DataWordSel=counter, DataWord=MemRData, CacheIndexWrite=captured index. Counter then increments.
  - Beats may be non-consecutive; DataWrite is low in gap cycles.
  - Beat order is word 0..3.
  - The beat with counter=3 moves the state to COMMIT. Counter wraps to 0.
- COMMIT:
  - Entered the cycle after the last DataWrite, so WriteValid is at least one cycle after the final data write.
  - For exactly one cycle: WriteValid=1, TagWrite=1, TagOut=captured tag, CacheIndexWrite=captured index, RefillDone=1, DoneThread=captured thread.
  - Busy stays 1 through COMMIT and drops the next cycle (state IDLE).
- Miss asserted during REQ/FILL/COMMIT is not captured. It is accepted only from IDLE, so the earliest back-to-back refill starts 1 cycle after Busy falls.
- A redundant refill of an already-valid line is legal: data is rewritten and WriteValid is set again, with no error.
- Valid memory read is registered, so a lookup in the COMMIT cycle sees the old bit. Fetch retries after RefillDone.
- A MemRValid during COMMIT is a protocol violation and is ignored.
- Latency: from Miss sampled to RefillDone = 1 (REQ entry) + ack wait + beat cycles + 2.
- Index width: CacheIndexWrite is 7 bits for INDEX_BITS=7 and matches the valid memory's write index.

Test Plan:
- Reset then idle: nReset=0 mid-run -> all strobes 0 immediately; after release with Miss=0 for 10 cycles, no MemReq and no WriteValid.
- Basic refill: Miss=1, MissAddr=0x0000_1234, thread 2; MemAck on the 3rd REQ cycle; 4 consecutive beats 0xA0..0xA3 -> MemAddr=0x0000_1230. DataWrite sequence is words 0..3 at index 0x23 with matching data. Then one cycle with WriteValid=1, TagOut=0x2, RefillDone=1, DoneThread=2. Busy drops the next cycle.
- Gapped beats: beats at cycles t, t+3, t+4, t+9 -> DataWrite exactly at t+1, t+4, t+5, t+10. WriteValid at t+11, never earlier.
- Index wrap: MissAddr=0xFFFF_FFF0 -> CacheIndexWrite=0x7F, TagOut=0x1F_FFFF, MemAddr=0xFFFF_FFF0.
- Reset mid-fill: nReset low after 2 beats -> no WriteValid/RefillDone; 2 late beats after release produce no DataWrite. A fresh Miss then refills normally.
- Miss while busy: Miss toggled during FILL with another address -> ignored. A second Miss held after RefillDone starts the next refill with MemReq 1 cycle after Busy falls.
